// File: rtl/sdff_scan_ctrl_pkg.sv
// rtl/sdff_scan_ctrl_pkg.sv - shared types and width helper for the scan-chain sequencer
//
// Contents:
//   state_t   : sequencer states (IDLE, SWAP1, RUN, SWAP2, DONE)
//   cnt_width : bits needed to hold the values 0..n (minimum 1)
package sdff_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SWAP1 = 3'd1,
        ST_RUN   = 3'd2,
        ST_SWAP2 = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int cnt_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < (n + 1)) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sdff_scan_ctrl_if.sv
// rtl/sdff_scan_ctrl_if.sv - host-side request/response bundle of the scan-chain sequencer
//
// Signals:
//   start_i   : operation request (host -> sequencer)
//   pattern_i : pattern to load, bit k lands in chain index k
//   steps_i   : functional cycles between the two swaps, 0 = single swap
//   busy_o    : sequencer not idle
//   done_o    : one-cycle end-of-operation pulse
//   result_o  : unloaded chain data, valid from done_o until the next accepted start
// Modports: master = host side, slave = sequencer side.
interface sdff_scan_ctrl_if #(
    parameter int CHAIN_LEN = 8,
    parameter int STEP_W    = 8
);
    logic                 start_i;
    logic [CHAIN_LEN-1:0] pattern_i;
    logic [STEP_W-1:0]    steps_i;
    logic                 busy_o;
    logic                 done_o;
    logic [CHAIN_LEN-1:0] result_o;

    modport master (
        output start_i, pattern_i, steps_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, pattern_i, steps_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/sdff_scan_ctrl.sv
// rtl/sdff_scan_ctrl.sv - scan-chain swap / what-if sequencer
//
// Ports:
//   clk_i, rst_ni : clock (shared with the chain flops), async active-low reset
//   host          : sdff_scan_ctrl_if.slave request/response bundle
//   scan_en_o     : scan-mux select for every chain cell
//   scan_d_o      : serial data into chain index CHAIN_LEN-1
//   scan_q_i      : Q of chain index 0
module sdff_scan_ctrl
    import sdff_scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int STEP_W    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    sdff_scan_ctrl_if.slave         host,
    output logic                    scan_en_o,
    output logic                    scan_d_o,
    input  logic                    scan_q_i
);

    localparam int              CNT_W    = cnt_width(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    state_t                 state, state_nx;
    logic [CHAIN_LEN-1:0]   sreg, sreg_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic [STEP_W-1:0]      step_cnt, step_cnt_nx;
    logic [STEP_W-1:0]      steps_q, steps_q_nx;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            sreg     <= '0;
            cnt      <= '0;
            step_cnt <= '0;
            steps_q  <= '0;
        end else begin
            state    <= state_nx;
            sreg     <= sreg_nx;
            cnt      <= cnt_nx;
            step_cnt <= step_cnt_nx;
            steps_q  <= steps_q_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        sreg_nx     = sreg;
        cnt_nx      = cnt;
        step_cnt_nx = step_cnt;
        steps_q_nx  = steps_q;
        case (state)
            ST_IDLE: begin
                if (host.start_i) begin
                    sreg_nx     = host.pattern_i;
                    steps_q_nx  = host.steps_i;
                    cnt_nx      = '0;
                    step_cnt_nx = '0;
                    state_nx    = ST_SWAP1;
                end
            end
            ST_SWAP1: begin
                // Chain's index-0 bit enters at the top; after CHAIN_LEN
                // shifts sreg holds the chain image in index order.
                sreg_nx = {scan_q_i, sreg[CHAIN_LEN-1:1]};
                if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    state_nx = (steps_q != '0) ? ST_RUN : ST_DONE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_RUN: begin
                // Count 0..steps-1 so the full-scale step value never wraps.
                if (step_cnt == steps_q - 1'b1) begin
                    step_cnt_nx = '0;
                    cnt_nx      = '0;
                    state_nx    = ST_SWAP2;
                end else begin
                    step_cnt_nx = step_cnt + 1'b1;
                end
            end
            ST_SWAP2: begin
                sreg_nx = {scan_q_i, sreg[CHAIN_LEN-1:1]};
                if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    state_nx = ST_DONE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Outputs decode the state register only, so async reset clears them at once.
    assign scan_en_o     = (state == ST_SWAP1) || (state == ST_SWAP2);
    assign scan_d_o      = sreg[0];
    assign host.busy_o   = (state != ST_IDLE);
    assign host.done_o   = (state == ST_DONE);
    assign host.result_o = sreg;

endmodule

// File: doc/sdff_scan_ctrl.md
Name: sdff_scan_ctrl

Overview:
Sequencer for a chain of CHAIN_LEN scan flops (mux-D flops with indicator LED, all clocked by clk_i). On request it performs a state swap or a "what-if" evaluation:
- shift in a pattern while unloading the live chain state;
- optionally run the functional logic for N steps;
- shift the original state back while unloading the result.

It sits between a debug/test host interface and the board-level scan chain.

Parameters:
CHAIN_LEN, 8, number of scan flops in the chain (>=2)
STEP_W, 8, width of functional step count
CNT_W, $clog2(CHAIN_LEN+1), derived width of the shift counter (localparam)

Ports:
clk_i  in  1  clock; also clocks the chain flops
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  operation request; sampled only in IDLE
pattern_i  in  CHAIN_LEN  pattern to load; bit k goes to chain index k
steps_i  in  STEP_W  functional cycles between swaps; 0 = single swap
busy_o  out  1  high in every non-IDLE state
done_o  out  1  one-cycle pulse at operation end
result_o  out  CHAIN_LEN  unloaded data; valid from done_o until the next accepted start
scan_en_o  out  1  scan-mux select for all chain cells
scan_d_o  out  1  serial data into the first chain cell
scan_q_i  in  1  Q of the last chain cell

Behaviour:
- Chain indexing: index 0 is the cell driving scan_q_i; index CHAIN_LEN-1 is the cell fed by scan_d_o.
- Reset (async, rst_ni=0): state=IDLE; busy_o=0, done_o=0, scan_en_o=0, result_o=0, shift register=0, counters=0. Takes effect immediately, including mid-shift; the chain is left with partial contents.
- Datapath: one CHAIN_LEN-bit shift register sreg.
  - scan_d_o = sreg[0]; result_o = sreg.
  - Every edge in SWAP1/SWAP2: sreg <= {scan_q_i, sreg[CHAIN_LEN-1:1]}.
- scan_en_o = 1 exactly in the SWAP1 and SWAP2 states, 0 otherwise. The chain runs functionally in IDLE/RUN/DONE.
- FSM:
  - IDLE: start_i=1 -> sreg<=pattern_i, steps latched, shift cnt<=0, go to SWAP1. Otherwise stay.
  - SWAP1: CHAIN_LEN cycles (cnt 0..CHAIN_LEN-1). Exit to RUN if steps!=0, else DONE. At exit sreg = chain contents of the first SWAP1 cycle; the chain holds the pattern.
  - RUN: exactly steps cycles with scan_en_o=0 (step counter), then SWAP2 with cnt<=0.
  - SWAP2: CHAIN_LEN cycles. Shifts the SWAP1-unloaded state back in; sreg captures the post-RUN chain state. Then DONE.
  - DONE: one cycle; done_o=1; then IDLE.
- Latency from the accepting edge:
  - steps=0: busy_o high CHAIN_LEN+1 cycles; done_o in cycle CHAIN_LEN+1.
  - steps=k>0: busy_o high 2*CHAIN_LEN+k+1 cycles.
- Start handling:
  - start_i is ignored outside IDLE (no queuing).
  - start_i held high yields back-to-back ops separated by one IDLE cycle.
  - pattern_i/steps_i are don't-care after acceptance.
- result_o is unstable while busy_o=1. It holds its value after DONE until the next accepted start.
- steps_i = 2^STEP_W-1 must complete without counter overflow.

Decomposition:
- sdff_scan_ctrl_pkg: state enum (IDLE, SWAP1, RUN, SWAP2, DONE) and the CNT_W derivation function.
- Single module; no sub-module needed. The shift counter and step counter stay inline.

Test Plan:
- Bench: CHAIN_LEN=8; behavioural chain of 8 sdff_led models; functional D per test.
- Reset with rst_ni=0 mid-SWAP1 (cycle 3) -> scan_en_o, busy_o, done_o drop to 0 immediately; result_o=0x00. Next start behaves normally.
- Hold chain (d=q), chain=0xA5, start pattern=0x3C steps=0 -> scan_en_o high exactly 8 cycles; done_o in cycle 9; result_o=0xA5; chain=0x3C afterwards.
- Hold chain, op1 pattern=0x3C steps=0 then op2 pattern=0x00 steps=0 -> op2 result_o=0x3C (round-trip ordering check).
- Toggle chain (d=~q), chain=0x0F in first SWAP1 cycle, pattern=0x55 steps=3 -> result_o=0xAA; chain=0x0F in the done_o cycle; busy_o high 20 cycles.
- start_i pulsed during SWAP2 -> ignored. start_i held high -> second op accepted in the IDLE cycle after DONE; exactly one done_o per op.
- Hold chain, steps=255 -> RUN lasts 255 cycles; busy_o high 272 cycles; result_o equals pattern.
